// File: rtl/kernel_activation_pkg.sv
// Shared activation mode codes, frame state encodings and default element width.
package kernel_activation_pkg;

   localparam int   BIT_DATA_DEF = 16;
   localparam logic ON           = 1'b1;

   typedef enum logic [1:0] {
      ACT_BYPASS = 2'b00,
      ACT_RELU   = 2'b01,
      ACT_LEAKY  = 2'b10,
      ACT_CLIP   = 2'b11
   } act_mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } frame_state_e;

endpackage

// File: rtl/kernel_activation_lane.sv
// One lane of the activation function plus its zero flag; purely combinational.
module kernel_activation_lane
   import kernel_activation_pkg::*;
#(
   parameter int BIT_DATA   = BIT_DATA_DEF,
   parameter int LEAK_SHIFT = 3
) (
   input  act_mode_e                   mode_i,
   input  logic signed [BIT_DATA-1:0]  x_i,
   input  logic signed [BIT_DATA-1:0]  clip_max_i,
   output logic signed [BIT_DATA-1:0]  y_o,
   output logic                        zero_o
);

   logic neg;
   assign neg = (x_i[BIT_DATA-1] == ON);

   always_comb begin
      y_o = x_i;
      case (mode_i)
         ACT_RELU:  if (neg) y_o = '0;
         ACT_LEAKY: if (neg) y_o = x_i >>> LEAK_SHIFT;
         ACT_CLIP: begin
            if (neg)                   y_o = '0;
            else if (x_i > clip_max_i) y_o = clip_max_i;
         end
         default:   y_o = x_i;
      endcase
   end

   assign zero_o = (y_o == '0);

endmodule

// File: rtl/kernel_activation.sv
// Multi-lane activation stage: two register stages under a single global enable,
// per-frame mode latch and saturating per-frame zero counter.
module kernel_activation
   import kernel_activation_pkg::*;
#(
   parameter int BIT_DATA   = BIT_DATA_DEF,
   parameter int LANES      = 4,
   parameter int LEAK_SHIFT = 3,
   parameter int CNT_W      = 16
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic [1:0]                mode_i,
   input  logic [BIT_DATA-1:0]       clip_max_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [LANES*BIT_DATA-1:0] in_data_i,
   input  logic                      in_last_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES*BIT_DATA-1:0] out_data_o,
   output logic                      out_last_o,
   output logic [LANES-1:0]          out_zero_mask_o,
   output logic [CNT_W-1:0]          out_zero_count_o
);

   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   frame_state_e              state_q;
   act_mode_e                 mode_q;
   logic [BIT_DATA-1:0]       clip_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          cnt_d;

   logic                      s1_vld_q;
   logic [LANES*BIT_DATA-1:0] s1_dat_q;
   logic                      s1_last_q;
   logic [LANES-1:0]          s1_mask_q;
   logic [CNT_W-1:0]          s1_cnt_q;

   logic                      out_valid_q;
   logic [LANES*BIT_DATA-1:0] out_data_q;
   logic                      out_last_q;
   logic [LANES-1:0]          out_mask_q;
   logic [CNT_W-1:0]          out_cnt_q;

   logic                      en;
   logic                      accept;
   act_mode_e                 mode_eff;
   logic [BIT_DATA-1:0]       clip_eff;
   logic [LANES*BIT_DATA-1:0] fn_dat;
   logic [LANES-1:0]          fn_zero;
   logic [CNT_W:0]            pop;
   logic [CNT_W:0]            cnt_sum;

   assign en         = !out_valid_q || out_ready_i;
   assign in_ready_o = en && !reset_i;
   assign accept     = in_valid_i && in_ready_o;

   // The first beat of a frame takes its mode straight from the pins; later beats use the latch.
   assign mode_eff = (state_q == ST_IDLE) ? act_mode_e'(mode_i) : mode_q;
   assign clip_eff = (state_q == ST_IDLE) ? clip_max_i : clip_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      kernel_activation_lane #(
         .BIT_DATA   (BIT_DATA),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .mode_i     (mode_eff),
         .x_i        (in_data_i[g*BIT_DATA +: BIT_DATA]),
         .clip_max_i (clip_eff),
         .y_o        (fn_dat[g*BIT_DATA +: BIT_DATA]),
         .zero_o     (fn_zero[g])
      );
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + (CNT_W+1)'(fn_zero[i]);
      end
      cnt_sum = {1'b0, cnt_q} + pop;
      cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= ACT_BYPASS;
         clip_q      <= '0;
         cnt_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_dat_q    <= '0;
         s1_last_q   <= 1'b0;
         s1_mask_q   <= '0;
         s1_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_mask_q  <= '0;
         out_cnt_q   <= '0;
      end else if (en) begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_dat_q  <= fn_dat;
            s1_mask_q <= fn_zero;
            s1_last_q <= in_last_i;
            // The last beat forwards the total including itself, then the running count restarts.
            s1_cnt_q  <= in_last_i ? cnt_d : '0;
            cnt_q     <= in_last_i ? '0 : cnt_d;
            if (state_q == ST_IDLE) begin
               mode_q <= mode_eff;
               clip_q <= clip_max_i;
            end
            state_q <= in_last_i ? ST_IDLE : ST_ACTIVE;
         end
         out_valid_q <= s1_vld_q;
         out_data_q  <= s1_dat_q;
         out_last_q  <= s1_vld_q && s1_last_q;
         out_mask_q  <= s1_mask_q;
         out_cnt_q   <= s1_vld_q ? s1_cnt_q : '0;
      end
   end

   assign out_valid_o      = out_valid_q;
   assign out_data_o       = out_data_q;
   assign out_last_o       = out_last_q;
   assign out_zero_mask_o  = out_mask_q;
   assign out_zero_count_o = out_cnt_q;

endmodule
